// File: rtl/hazard_pkg.sv
// Shared encodings for the decode-stage control-hazard sequencer.
// Source codes are ordered by priority, so a numeric compare ranks them.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_IDLE  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_JMP  = 2'b01,
    SRC_BR   = 2'b10,
    SRC_INT  = 2'b11
  } src_t;

  function automatic logic outranks(src_t a, src_t b);
    return 2'(a) > 2'(b);
  endfunction

endpackage

// File: rtl/hdu_down_counter.sv
// Loadable down-counter used for start-up and flush lengths.
// Load wins over decrement.
module hdu_down_counter #(
  parameter int CNT_W   = 2,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/control_hazard_sequencer.sv
// Decode-stage sequencer: start-up stall, per-class multi-cycle flushes with
// priority pre-emption, and zero-latency load-use bubbles.
module control_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter int JMP_FLUSH      = 1,
  parameter int BR_FLUSH       = 2,
  parameter int INT_FLUSH      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jump_req,
  input  logic       branch_taken,
  input  logic       int_req,
  input  logic       load_use,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       redirect,
  output logic [1:0] redirect_src,
  output logic       busy
);

  localparam int MAX_AB = (STARTUP_CYCLES > JMP_FLUSH) ? STARTUP_CYCLES : JMP_FLUSH;
  localparam int MAX_CD = (BR_FLUSH > INT_FLUSH) ? BR_FLUSH : INT_FLUSH;
  localparam int MAX_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  state_t           state_q, state_d;
  src_t             src_q, src_d;
  src_t             evt_src;
  logic             preempt;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;

  hdu_down_counter #(
    .CNT_W  (CNT_W),
    .RST_VAL(STARTUP_CYCLES)
  ) u_cnt (
    .clk     (clk),
    .rst     (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .cnt     (cnt_val),
    .is_one  (cnt_is_one)
  );

  // Only the highest-priority request is seen; the rest are dropped, not queued.
  always_comb begin
    evt_src = SRC_NONE;
    if (int_req) begin
      evt_src = SRC_INT;
    end else if (branch_taken) begin
      evt_src = SRC_BR;
    end else if (jump_req) begin
      evt_src = SRC_JMP;
    end
    case (evt_src)
      SRC_INT: cnt_load_val = CNT_W'(INT_FLUSH);
      SRC_BR:  cnt_load_val = CNT_W'(BR_FLUSH);
      default: cnt_load_val = CNT_W'(JMP_FLUSH);
    endcase
    preempt = outranks(evt_src, src_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_START;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_START: begin
        cnt_dec = 1'b1;
        // A zero count can only come from a misconfigured STARTUP_CYCLES; leave anyway.
        if (cnt_is_one || (cnt_val == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (evt_src != SRC_NONE) begin
          state_d  = ST_FLUSH;
          src_d    = evt_src;
          cnt_load = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (preempt) begin
          src_d    = evt_src;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
      end
    endcase
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    redirect     = 1'b0;
    redirect_src = SRC_NONE;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_START: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      ST_IDLE: begin
        if (evt_src != SRC_NONE) begin
          redirect     = 1'b1;
          redirect_src = evt_src;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_if_id  = 1'b1;
        flush_id_ex  = (src_q != SRC_JMP);
        redirect     = preempt;
        redirect_src = preempt ? evt_src : src_q;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_hazard_sequencer.sv
// Bench for control_hazard_sequencer: two configurations driven in lockstep,
// a directed vector table, an async-reset sequence and a randomized run.
module tb_control_hazard_sequencer;

  logic clk = 1'b0;
  logic reset, jump_req, branch_taken, int_req, load_use;
  logic       a_stall_pc, a_stall_if_id, a_flush_if_id, a_flush_id_ex, a_redirect, a_busy;
  logic [1:0] a_redirect_src;
  logic       b_stall_pc, b_stall_if_id, b_flush_if_id, b_flush_id_ex, b_redirect, b_busy;
  logic [1:0] b_redirect_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_hazard_sequencer dut_a (
    .clk(clk), .reset(reset), .jump_req(jump_req), .branch_taken(branch_taken),
    .int_req(int_req), .load_use(load_use), .stall_pc(a_stall_pc),
    .stall_if_id(a_stall_if_id), .flush_if_id(a_flush_if_id), .flush_id_ex(a_flush_id_ex),
    .redirect(a_redirect), .redirect_src(a_redirect_src), .busy(a_busy)
  );

  control_hazard_sequencer #(.STARTUP_CYCLES(1), .INT_FLUSH(5)) dut_b (
    .clk(clk), .reset(reset), .jump_req(jump_req), .branch_taken(branch_taken),
    .int_req(int_req), .load_use(load_use), .stall_pc(b_stall_pc),
    .stall_if_id(b_stall_if_id), .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex),
    .redirect(b_redirect), .redirect_src(b_redirect_src), .busy(b_busy)
  );

  // Output vector layout: {redirect, redirect_src[1:0], flush_if_id, flush_id_ex, stall_pc, stall_if_id, busy}
  localparam logic [7:0] V_START = 8'b0_00_1_1_1_0_1;
  localparam logic [7:0] V_IDLE  = 8'b0_00_0_0_0_0_0;
  localparam logic [7:0] V_RJ    = 8'b1_01_0_0_0_0_0;
  localparam logic [7:0] V_RB    = 8'b1_10_0_0_0_0_0;
  localparam logic [7:0] V_RI    = 8'b1_11_0_0_0_0_0;
  localparam logic [7:0] V_FJ    = 8'b0_01_1_0_0_0_1;
  localparam logic [7:0] V_FB    = 8'b0_10_1_1_0_0_1;
  localparam logic [7:0] V_FI    = 8'b0_11_1_1_0_0_1;
  localparam logic [7:0] V_FB_PI = 8'b1_11_1_1_0_0_1;
  localparam logic [7:0] V_FJ_PB = 8'b1_10_1_0_0_0_1;
  localparam logic [7:0] V_LU    = 8'b0_00_0_1_1_1_0;

  // Reference model: remaining start-up cycles, remaining flush cycles, active class.
  int startup_n[2] = '{2, 1};
  int jmp_n[2]     = '{1, 1};
  int br_n[2]      = '{2, 2};
  int int_n[2]     = '{3, 5};
  int start_left[2];
  int flush_left[2];
  int cur[2];

  logic [7:0] act_a, act_b;

  function automatic int evt_code(logic j, logic b, logic i);
    if (i) return 3;
    if (b) return 2;
    if (j) return 1;
    return 0;
  endfunction

  function automatic int class_len(int m, int code);
    if (code == 3) return int_n[m];
    if (code == 2) return br_n[m];
    return jmp_n[m];
  endfunction

  function automatic logic [7:0] model_out(int m, logic j, logic b, logic i, logic l);
    int e;
    e = evt_code(j, b, i);
    if (start_left[m] > 0) return V_START;
    if (flush_left[m] > 0) begin
      if (e > cur[m]) return {1'b1, 2'(e), 1'b1, 1'(cur[m] >= 2), 3'b001};
      return {1'b0, 2'(cur[m]), 1'b1, 1'(cur[m] >= 2), 3'b001};
    end
    if (e > 0) return {1'b1, 2'(e), 5'b00000};
    if (l) return V_LU;
    return V_IDLE;
  endfunction

  task automatic model_reset(int m);
    start_left[m] = startup_n[m];
    flush_left[m] = 0;
    cur[m]        = 0;
  endtask

  task automatic model_tick(int m, logic j, logic b, logic i);
    int e;
    e = evt_code(j, b, i);
    if (start_left[m] > 0) begin
      start_left[m]--;
    end else if (flush_left[m] > 0) begin
      if (e > cur[m]) begin
        cur[m]        = e;
        flush_left[m] = class_len(m, e);
      end else begin
        flush_left[m]--;
        if (flush_left[m] == 0) cur[m] = 0;
      end
    end else if (e > 0) begin
      cur[m]        = e;
      flush_left[m] = class_len(m, e);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare mid-cycle, advance model at the rising edge.
  task automatic step(input logic r, input logic j, input logic b, input logic i, input logic l);
    @(negedge clk);
    reset = r; jump_req = j; branch_taken = b; int_req = i; load_use = l;
    if (r) begin
      model_reset(0);
      model_reset(1);
    end
    #1;
    act_a = {a_redirect, a_redirect_src, a_flush_if_id, a_flush_id_ex, a_stall_pc, a_stall_if_id, a_busy};
    act_b = {b_redirect, b_redirect_src, b_flush_if_id, b_flush_id_ex, b_stall_pc, b_stall_if_id, b_busy};
    check("model_a", act_a, model_out(0, j, b, i, l));
    check("model_b", act_b, model_out(1, j, b, i, l));
    @(posedge clk);
    if (!r) begin
      model_tick(0, j, b, i);
      model_tick(1, j, b, i);
    end
  endtask

  typedef struct {
    logic       j, b, i, l;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic [3:0] jbil, logic [7:0] exp);
    vec_t v;
    v.j = jbil[3]; v.b = jbil[2]; v.i = jbil[1]; v.l = jbil[0]; v.exp = exp;
    return v;
  endfunction

  initial begin
    reset = 1'b1; jump_req = 1'b0; branch_taken = 1'b0; int_req = 1'b0; load_use = 1'b0;
    model_reset(0);
    model_reset(1);

    tbl[0]  = mk(4'b1000, V_START);  tbl[1]  = mk(4'b0000, V_START);
    tbl[2]  = mk(4'b0000, V_IDLE);   tbl[3]  = mk(4'b1000, V_RJ);
    tbl[4]  = mk(4'b0000, V_FJ);     tbl[5]  = mk(4'b0000, V_IDLE);
    tbl[6]  = mk(4'b0100, V_RB);     tbl[7]  = mk(4'b0010, V_FB_PI);
    tbl[8]  = mk(4'b0000, V_FI);     tbl[9]  = mk(4'b0000, V_FI);
    tbl[10] = mk(4'b0000, V_FI);     tbl[11] = mk(4'b0000, V_IDLE);
    tbl[12] = mk(4'b0001, V_LU);     tbl[13] = mk(4'b1001, V_RJ);
    tbl[14] = mk(4'b0000, V_FJ);     tbl[15] = mk(4'b0010, V_RI);
    tbl[16] = mk(4'b0100, V_FI);     tbl[17] = mk(4'b0001, V_FI);
    tbl[18] = mk(4'b1000, V_FI);     tbl[19] = mk(4'b0000, V_IDLE);
    tbl[20] = mk(4'b1000, V_RJ);     tbl[21] = mk(4'b0100, V_FJ_PB);
    tbl[22] = mk(4'b0000, V_FB);     tbl[23] = mk(4'b0000, V_FB);
    tbl[24] = mk(4'b0000, V_IDLE);   tbl[25] = mk(4'b1111, V_RI);
    tbl[26] = mk(4'b0000, V_FI);     tbl[27] = mk(4'b0000, V_FI);
    tbl[28] = mk(4'b0000, V_FI);     tbl[29] = mk(4'b0000, V_IDLE);

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_a", act_a, V_START);
    check("reset_b", act_b, V_START);

    for (int k = 0; k < 30; k++) begin
      step(1'b0, tbl[k].j, tbl[k].b, tbl[k].i, tbl[k].l);
      check($sformatf("tbl[%0d]", k), act_a, tbl[k].exp);
    end

    // Asynchronous reset in the middle of an interrupt flush.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("int_accept_a", act_a, V_RI);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("int_flush_a", act_a, V_FI);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("async_rst_a", act_a, V_START);
    check("async_rst_b", act_b, V_START);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart0_a", act_a, V_START);
    check("restart0_b", act_b, V_START);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart1_a", act_a, V_START);
    check("restart1_b", act_b, V_IDLE);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart2_a", act_a, V_RI);
    check("restart2_b", act_b, V_RI);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("int5_flush_b", act_b, V_FI);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("int5_flush_last_b", act_b, V_FI);
    check("int3_done_a", act_a, V_IDLE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("int5_done_b", act_b, V_IDLE);

    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_hazard_sequencer.md
# control_hazard_sequencer

Parametrised control-hazard and bubble sequencer for the decode stage. Generates the pipeline start-up stall after reset, multi-cycle IF/ID and ID/EX flushes for unconditional jumps, taken branches and interrupts, and single-cycle load-use bubbles. Flush depth is set per event class. A higher-priority event arriving during an active flush pre-empts it. Sits beside the decode-stage hazard logic and drives the PC, IF/ID and ID/EX register controls.

## Interface
Parameters:
- STARTUP_CYCLES, 2: cycles of full stall/flush after reset release; must be ≥1.
- JMP_FLUSH, 1: flush cycles for an unconditional jump; must be ≥1.
- BR_FLUSH, 2: flush cycles for a taken branch; must be ≥1.
- INT_FLUSH, 3: flush cycles for an interrupt; must be ≥1.
- CNT_W, derived as $clog2(max of the four above + 1): width of the down-counter.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high.
- jump_req, in, 1: unconditional jump decoded in ID.
- branch_taken, in, 1: branch resolved taken in EX.
- int_req, in, 1: interrupt request (level).
- load_use, in, 1: load-use hazard detected in ID.
- stall_pc, out, 1: hold PC.
- stall_if_id, out, 1: hold IF/ID register.
- flush_if_id, out, 1: clear IF/ID register.
- flush_id_ex, out, 1: insert bubble into ID/EX.
- redirect, out, 1: one-cycle pulse when an event is accepted.
- redirect_src, out, 2: 00 none, 01 jump, 10 branch, 11 interrupt. Holds the latched source while busy.
- busy, out, 1: high whenever state ≠ IDLE.

## Operation
States: START, IDLE, FLUSH. A loadable down-counter cnt and a latched source src are held alongside the state.

- **Reset:** state=START, cnt=STARTUP_CYCLES, src=00.
- **START outputs:** stall_pc=1, flush_if_id=1, flush_id_ex=1; stall_if_id=0, redirect=0.
- **START behaviour:** all requests are ignored and dropped. cnt decrements each cycle. When cnt==1, the next state is IDLE.
- **IDLE, event acceptance:** priority is int_req > branch_taken > jump_req. An accepted event drives redirect=1 and redirect_src combinationally in the same cycle. Next state is FLUSH, with cnt loaded from that class's FLUSH parameter and src latched.
- **IDLE, load-use:** when no event is present and load_use=1, drive stall_pc=1, stall_if_id=1, flush_id_ex=1 combinationally, and stay in IDLE.
- **FLUSH outputs:** flush_if_id=1 every cycle. flush_id_ex=1 when src is branch or interrupt, and 0 for jump. stall_* outputs are 0. load_use is ignored.
- **FLUSH pre-emption:** an event with strictly higher priority than src drives redirect=1, reloads cnt from its own parameter and updates src. Equal or lower priority events are ignored.
- **FLUSH exit:** with no pre-emption, cnt decrements. When cnt==1, the next state is IDLE and src clears to 00.
- **IDLE outputs otherwise:** all outputs 0 and redirect_src=00, except the combinational cases above.
- **Reset mid-operation:** immediately forces START, regardless of state or counter.

## Timing
- Reset deassertion: flush/stall are high for exactly STARTUP_CYCLES cycles, then busy falls.
- Event accepted in cycle t: redirect is high in t only. flush_* are high in cycles t+1 … t+N, where N is the class parameter. busy is high over the same span.
- Load-use bubble: zero latency, lasting exactly the cycles in which load_use is high in IDLE.
- Simultaneous load_use and any event in IDLE: the event wins and no stall is asserted.
- Simultaneous events: only the highest priority is accepted. Lower-priority requests are not queued.
- Pre-emption in cycle t: the flush continues without a gap and ends N_new cycles after t.
- An event arriving in the last FLUSH cycle (cnt==1) is handled by the pre-emption rule only. Otherwise it is dropped.

## Structure
- Shared package hazard_pkg holds:
  - state encoding: START=2'b00, IDLE=2'b01, FLUSH=2'b10;
  - src codes: SRC_NONE, SRC_JMP, SRC_BR, SRC_INT;
  - a priority-compare function.
- One sub-module, hdu_down_counter (parameter CNT_W), with ports load, load_val, dec, cnt and is_one.

## Test plan
- Reset with defaults, release at cycle 0 → flush_if_id/flush_id_ex/stall_pc high for cycles 0–1; busy low from cycle 2. A jump_req during START produces no redirect.
- IDLE, jump_req pulse at t → redirect=1, src=01 at t; flush_if_id high t+1 only; flush_id_ex stays 0.
- IDLE, branch_taken at t, int_req at t+1 → redirect at t (src=10) and at t+1 (src=11); flush high t+1 … t+4 with no gap; flush_id_ex high throughout.
- IDLE, load_use high for 2 cycles with jump_req in the 2nd → cycle 1: stall_pc=stall_if_id=flush_id_ex=1; cycle 2: redirect, stalls 0; flush_if_id high next cycle.
- FLUSH on interrupt (cnt=3), branch_taken asserted → ignored, no redirect, flush ends after 3 cycles.
- Assert reset asynchronously mid-FLUSH → outputs go to START values immediately; after release, the START sequence runs for STARTUP_CYCLES; repeat with STARTUP_CYCLES=1 and INT_FLUSH=5.
